// File: rtl/serial_bus_pkg.sv
// Shared serial-bus definitions used by both the master transmit stage and the slave input port.
package serial_bus_pkg;

  localparam int unsigned DEF_ADDR_W  = 12;
  localparam int unsigned DEF_DATA_W  = 8;
  localparam int unsigned DEF_BURST_W = 12;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_RDY,
    ST_ADDR,
    ST_FETCH,
    ST_DATA,
    ST_DONE
  } mop_state_t;

endpackage

// File: rtl/serial_shift_out.sv
// Parallel-load, LSB-first shift register; shifts zeros in from the top so it idles at 0 once drained.
module serial_shift_out #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic         i_shift_en,
  input  logic         i_ready,
  input  logic [W-1:0] i_pdata,
  output logic         o_sout
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_pdata;
    end else if (i_shift_en && i_ready) begin
      r_q <= {1'b0, r_q[W-1:1]};
    end
  end

  assign o_sout = r_q[0];

endmodule

// File: rtl/master_out_port.sv
// Master-side serial transmit stage: serializes address and write bytes toward the slave input port,
// pausing whenever the slave deasserts s_ready.
module master_out_port
  import serial_bus_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned BURST_W = DEF_BURST_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               rw,
  input  logic [ADDR_W-1:0]  addr_in,
  input  logic [BURST_W-1:0] burst_len,
  input  logic [DATA_W-1:0]  wdata,
  input  logic               wdata_valid,
  output logic               wdata_ready,
  input  logic               s_ready,
  output logic               m_valid,
  output logic               write_enable,
  output logic               read_enable,
  output logic               tx_address,
  output logic               tx_data,
  output logic               busy,
  output logic               tx_done
);

  localparam int unsigned CNT_W = $clog2(ADDR_W);

  mop_state_t         r_state;
  logic               r_rw;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_byte;
  logic [BURST_W-1:0] r_beats;
  logic [CNT_W-1:0]   r_bit;
  logic               r_wdata_ready;
  logic               r_m_valid;
  logic               r_we;
  logic               r_re;
  logic               r_busy;
  logic               r_tx_done;

  logic              w_accept;
  logic              w_addr_load;
  logic              w_fetch;
  logic              w_data_load;
  logic              w_shift;
  logic              w_last;
  logic              w_more;
  logic [DATA_W-1:0] w_data_pin;

  assign w_accept    = (r_state == ST_IDLE) && start && ((rw == RW_READ) || wdata_valid);
  assign w_addr_load = (r_state == ST_WAIT_RDY) && s_ready;
  assign w_fetch     = (r_state == ST_FETCH) && wdata_valid;
  assign w_data_load = w_addr_load || w_fetch;
  assign w_data_pin  = w_fetch ? wdata : r_byte;
  assign w_shift     = (r_state == ST_ADDR) || (r_state == ST_DATA);
  assign w_last      = ((r_state == ST_ADDR) && (r_bit == CNT_W'(ADDR_W - 1))) ||
                       ((r_state == ST_DATA) && (r_bit == CNT_W'(DATA_W - 1)));
  assign w_more      = (r_rw == RW_WRITE) && (r_beats > BURST_W'(1));

  // Shift registers hold zero outside their active phases, so the bit outputs come straight off flops.
  serial_shift_out #(.W(ADDR_W)) u_addr_sh (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_addr_load),
    .i_shift_en (w_shift),
    .i_ready    (s_ready),
    .i_pdata    (r_addr),
    .o_sout     (tx_address)
  );

  serial_shift_out #(.W(DATA_W)) u_data_sh (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_data_load),
    .i_shift_en (w_shift),
    .i_ready    (s_ready),
    .i_pdata    (w_data_pin),
    .o_sout     (tx_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_rw          <= 1'b0;
      r_addr        <= '0;
      r_byte        <= '0;
      r_beats       <= '0;
      r_bit         <= '0;
      r_wdata_ready <= 1'b0;
      r_m_valid     <= 1'b0;
      r_we          <= 1'b0;
      r_re          <= 1'b0;
      r_busy        <= 1'b0;
      r_tx_done     <= 1'b0;
    end else begin
      r_wdata_ready <= 1'b0;
      r_tx_done     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_rw          <= rw;
            r_addr        <= addr_in;
            r_byte        <= (rw == RW_WRITE) ? wdata : '0;
            r_beats       <= (burst_len == '0) ? BURST_W'(1) : burst_len;
            r_wdata_ready <= (rw == RW_WRITE);
            r_m_valid     <= 1'b1;
            r_we          <= rw;
            r_re          <= ~rw;
            r_busy        <= 1'b1;
            r_state       <= ST_WAIT_RDY;
          end
        end
        ST_WAIT_RDY: begin
          if (s_ready) begin
            r_bit   <= '0;
            r_state <= ST_ADDR;
          end
        end
        ST_ADDR, ST_DATA: begin
          if (s_ready) begin
            if (w_last) begin
              r_bit <= '0;
              if (w_more) begin
                r_beats <= r_beats - BURST_W'(1);
                r_state <= ST_FETCH;
              end else begin
                r_m_valid <= 1'b0;
                r_we      <= 1'b0;
                r_re      <= 1'b0;
                r_tx_done <= 1'b1;
                r_state   <= ST_DONE;
              end
            end else begin
              r_bit <= r_bit + CNT_W'(1);
            end
          end
        end
        ST_FETCH: begin
          if (wdata_valid) begin
            r_wdata_ready <= 1'b1;
            r_bit         <= '0;
            r_state       <= ST_DATA;
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign wdata_ready  = r_wdata_ready;
  assign m_valid      = r_m_valid;
  assign write_enable = r_we;
  assign read_enable  = r_re;
  assign busy         = r_busy;
  assign tx_done      = r_tx_done;

endmodule

// File: tb/tb_master_out_port.sv
// Scoreboard bench for master_out_port: commands push expected transfers, a bus monitor decodes and compares.
module tb_master_out_port;

  localparam int P_IDLE = 0, P_WAIT = 1, P_ADDR = 2, P_FETCH = 3, P_DATA = 4,
                 P_END = 5, P_POST = 6, P_ORPH = 7;

  typedef struct {
    logic        rw;
    logic [11:0] addr;
    int          nbytes;
    int          exp_len;
  } cmd_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        rw = 1'b0;
  logic [11:0] addr_in = '0;
  logic [11:0] burst_len = '0;
  logic [7:0]  wdata = '0;
  logic        wdata_valid = 1'b0;
  logic        s_ready = 1'b0;
  logic        wdata_ready, m_valid, write_enable, read_enable;
  logic        tx_address, tx_data, busy, tx_done;

  int n_total = 0;
  int n_bad   = 0;

  int ready_mode = 0;  // 0 always ready, 1 random, 2 follow force_low
  bit force_low  = 1'b0;
  bit starve     = 1'b0;
  bit valid_rand = 1'b0;

  cmd_t       exp_q[$];
  logic [7:0] exp_bytes[$];
  logic [7:0] src_q[$];

  master_out_port dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .rw           (rw),
    .addr_in      (addr_in),
    .burst_len    (burst_len),
    .wdata        (wdata),
    .wdata_valid  (wdata_valid),
    .wdata_ready  (wdata_ready),
    .s_ready      (s_ready),
    .m_valid      (m_valid),
    .write_enable (write_enable),
    .read_enable  (read_enable),
    .tx_address   (tx_address),
    .tx_data      (tx_data),
    .busy         (busy),
    .tx_done      (tx_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Byte source and slave-ready driver, updated just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (rst) src_q.delete();
    else if (wdata_ready && src_q.size() > 0) void'(src_q.pop_front());
    wdata_valid = (src_q.size() > 0) && !starve && (!valid_rand || ($urandom_range(0, 3) != 0));
    wdata       = (src_q.size() > 0) ? src_q[0] : 8'h00;
    case (ready_mode)
      0:       s_ready = 1'b1;
      1:       s_ready = ($urandom_range(0, 3) != 0);
      default: s_ready = !force_low;
    endcase
  end

  // Bus monitor: decodes each transfer from the pins and compares against the scoreboard.
  cmd_t        cur;
  int          ph = P_IDLE;
  int          idx, len, rdy_cnt, nbeat, bytes_left;
  logic        prev_rdy;
  logic [7:0]  cur_byte;
  logic [11:0] got_a, got_d;
  logic [7:0]  got_b;

  always @(negedge clk) begin
    if (rst) begin
      if (ph != P_IDLE)
        while (bytes_left > 0) begin
          void'(exp_bytes.pop_front());
          bytes_left--;
        end
      ph = P_IDLE;
    end else begin
      if (ph == P_POST) begin
        chk("tx_done_width", tx_done, 0);
        ph = P_IDLE;
      end else if (ph == P_END) begin
        chk("end_mvalid", m_valid, 0);
        chk("tx_done", tx_done, 1);
        if (cur.exp_len > 0) chk("mvalid_len", len, cur.exp_len);
        chk("wdata_ready_cnt", rdy_cnt, cur.nbytes);
        ph = P_POST;
      end else if (ph == P_ORPH) begin
        if (!m_valid) ph = P_IDLE;
      end
      if (ph == P_IDLE && m_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_xfer", 1, 0);
          ph = P_ORPH;
        end else begin
          cur = exp_q.pop_front();
          len = 0; rdy_cnt = 0; nbeat = 0; prev_rdy = 1'b0;
          bytes_left = cur.nbytes;
          cur_byte = 8'h00;
          if (cur.nbytes > 0 && exp_bytes.size() > 0) begin
            cur_byte = exp_bytes.pop_front();
            bytes_left--;
          end
          ph = P_WAIT;
        end
      end
      if (ph >= P_WAIT && ph <= P_DATA) begin
        len++;
        chk("mvalid_hold", m_valid, 1);
        chk("enables", {write_enable, read_enable}, {cur.rw, ~cur.rw});
        chk("busy", busy, 1);
        if (wdata_ready) begin
          rdy_cnt++;
          chk("ready_b2b", prev_rdy, 0);
        end
        prev_rdy = wdata_ready;
        if (ph == P_WAIT) begin
          chk("wait_tx", {tx_address, tx_data}, 0);
          if (s_ready) begin ph = P_ADDR; idx = 0; end
        end else if (ph == P_ADDR) begin
          if (s_ready) begin
            got_a[idx] = tx_address;
            got_d[idx] = tx_data;
            idx++;
            if (idx == 12) begin
              chk("addr", got_a, cur.addr);
              chk("addr_phase_data", got_d, {4'h0, cur_byte});
              nbeat = 1;
              ph = (nbeat < cur.nbytes) ? P_FETCH : P_END;
            end
          end
        end else begin
          if (ph == P_FETCH) begin
            if (wdata_ready) begin
              ph = P_DATA; idx = 0;
              cur_byte = (exp_bytes.size() > 0) ? exp_bytes.pop_front() : 8'h00;
              bytes_left--;
            end else begin
              chk("fetch_tx", {tx_address, tx_data}, 0);
            end
          end
          if (ph == P_DATA) begin
            chk("data_txaddr", tx_address, 0);
            if (s_ready) begin
              got_b[idx] = tx_data;
              idx++;
              if (idx == 8) begin
                chk("data_byte", got_b, cur_byte);
                nbeat++;
                ph = (nbeat < cur.nbytes) ? P_FETCH : P_END;
              end
            end
          end
        end
      end
    end
  end

  // Queues the expected transfer and bytes, then holds start until the command is taken.
  task automatic issue(input logic i_rw, input logic [11:0] a, input logic [11:0] bl,
                       input bit fixed, input logic [7:0] b0, input bit timed, input int extra);
    cmd_t c;
    int   n;
    bit   ok;
    n = i_rw ? ((bl == 12'd0) ? 1 : int'(bl)) : 0;
    c.rw = i_rw; c.addr = a; c.nbytes = n;
    c.exp_len = timed ? ((i_rw ? 13 + 9 * (n - 1) : 13) + extra) : 0;
    for (int k = 0; k < n; k++) begin
      logic [7:0] b;
      b = fixed ? 8'(b0 * (k + 1)) : 8'($urandom);
      exp_bytes.push_back(b);
      src_q.push_back(b);
    end
    exp_q.push_back(c);
    @(posedge clk); #2;
    start = 1'b1; rw = i_rw; addr_in = a; burst_len = bl;
    ok = 1'b0;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(posedge clk); #2;
      if (busy) ok = 1'b1;
    end
    start = 1'b0;
    chk("accept", ok, 1);
    chk("mvalid_latency", m_valid, 1);
  endtask

  task automatic wait_idle(input int limit);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < limit && !ok; t++) begin
      @(posedge clk); #2;
      if (!busy) ok = 1'b1;
    end
    chk("idle_timeout", ok, 1);
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #12;
    chk("reset_outputs", {m_valid, write_enable, read_enable, tx_address, tx_data,
                          busy, tx_done, wdata_ready}, 0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #2;
    chk("idle_busy", busy, 0);

    // Read of 0xA5C with the slave always ready.
    issue(1'b0, 12'hA5C, 12'd0, 1'b0, 8'h00, 1'b1, 0);
    wait_idle(100);
    // Single write, burst_len 0 counts as one beat.
    issue(1'b1, 12'h001, 12'd0, 1'b1, 8'hB3, 1'b1, 0);
    wait_idle(100);
    // Three-beat burst 0x11, 0x22, 0x33.
    issue(1'b1, 12'h3F0, 12'd3, 1'b1, 8'h11, 1'b1, 0);
    wait_idle(200);

    // Slave stall for three cycles while address bit 5 is on the wire.
    ready_mode = 2;
    issue(1'b0, 12'hA5C, 12'd0, 1'b0, 8'h00, 1'b1, 3);
    repeat (5) @(posedge clk); #2;
    force_low = 1'b1;
    repeat (3) @(posedge clk); #2;
    force_low = 1'b0;
    wait_idle(100);
    ready_mode = 0;

    // Byte source starved for five cycles after the first beat.
    issue(1'b1, 12'h7E5, 12'd2, 1'b0, 8'h00, 1'b0, 0);
    exp_q[exp_q.size() - 1].exp_len = 27;
    #1 starve = 1'b1;
    repeat (17) @(posedge clk); #2;
    starve = 1'b0;
    wait_idle(200);

    // Reset asserted while data bit 3 of the second beat is on the wire.
    issue(1'b1, 12'h155, 12'd2, 1'b0, 8'h00, 1'b0, 0);
    repeat (17) @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("midrst_outputs", {m_valid, write_enable, read_enable, tx_address, tx_data,
                           busy, tx_done, wdata_ready}, 0);
    repeat (2) begin
      @(posedge clk); #2;
      chk("midrst_no_done", tx_done, 0);
    end
    rst = 1'b0;
    @(posedge clk); #2;
    chk("midrst_no_done_after", tx_done, 0);
    issue(1'b1, 12'h2C9, 12'd1, 1'b0, 8'h00, 1'b1, 0);
    wait_idle(100);

    // Longest burst the counter allows.
    issue(1'b1, 12'hFFF, 12'd4095, 1'b0, 8'h00, 1'b1, 0);
    wait_idle(40000);

    // Randomized commands with random slave stalls and source gaps.
    ready_mode = 1;
    valid_rand = 1'b1;
    for (int i = 0; i < 25; i++) begin
      logic        r;
      logic [11:0] bl;
      r  = 1'($urandom);
      bl = 12'($urandom_range(0, 6));
      issue(r, 12'($urandom), bl, 1'b0, 8'h00, 1'b0, 0);
      wait_idle(5000);
    end
    ready_mode = 0;
    valid_rand = 1'b0;

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #4000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/master_out_port.md
# master_out_port

Master-side serial transmit stage of the serial bus; it sits directly upstream of the slave input port. It accepts a parallel command from the master core: read/write, 12-bit start address, burst length and write bytes. It serializes the address onto `tx_address` and write bytes onto `tx_data`, and drives `m_valid`, `write_enable` and `read_enable` toward the slave, pausing whenever the slave deasserts `s_ready`.

## Interface
- `ADDR_W`, 12, address width / address bits per transfer
- `DATA_W`, 8, data byte width / data bits per beat
- `BURST_W`, 12, burst length counter width
- `clk`  in  1  bus clock, all logic on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  command request, sampled only in IDLE
- `rw`  in  1  1 = write, 0 = read
- `addr_in`  in  ADDR_W  start address
- `burst_len`  in  BURST_W  write beats, 1..4095; 0 treated as 1; ignored for reads
- `wdata`  in  DATA_W  write byte
- `wdata_valid`  in  1  `wdata` holds a byte
- `wdata_ready`  out  1  byte consumed this cycle
- `s_ready`  in  1  slave can accept bits
- `m_valid`  out  1  transfer in progress on bus
- `write_enable`  out  1  current transfer is a write
- `read_enable`  out  1  current transfer is a read
- `tx_address`  out  1  serial address bit, LSB first
- `tx_data`  out  1  serial data bit, LSB first
- `busy`  out  1  not IDLE
- `tx_done`  out  1  one-cycle pulse at end of transfer

## Operation
- States: IDLE, WAIT_RDY, ADDR, FETCH, DATA, DONE.
- IDLE:
  - Command accepted when `start` and (`rw`=0 or `wdata_valid`).
  - Latch `addr_in`, `rw` and burst count, where count = `burst_len`, or 1 if zero.
  - For writes, latch `wdata` and pulse `wdata_ready` in the same cycle.
  - Go to WAIT_RDY.
- WAIT_RDY:
  - `m_valid`=1; enable = `rw` (`write_enable`) or `!rw` (`read_enable`); `tx_*`=0.
  - Go to ADDR on the first cycle `s_ready`=1.
- ADDR: 12 bit-cycles, bit counter 0..11.
  - `tx_address` = addr[i].
  - `tx_data` = byte[i] for i<8 on writes; 0 for i≥8 and for reads.
  - After i=11:
    - Write with beats remaining >1: decrement and go to FETCH.
    - Otherwise go to DONE.
- FETCH:
  - `m_valid` stays 1; `tx_*`=0.
  - On `wdata_valid`, pulse `wdata_ready`, latch the byte and go to DATA.
- DATA:
  - 8 bit-cycles; `tx_data` = byte[j]; `tx_address`=0. The slave auto-increments the address.
  - After j=7: remaining >1 → decrement and go to FETCH; else go to DONE.
- DONE:
  - `m_valid`=0, enables 0, `tx_done`=1 for one cycle, then IDLE.
- Stall rule: in ADDR or DATA, a cycle with `s_ready`=0 does not advance the bit counter. Bit outputs, `m_valid` and enables hold their values.
- `start` outside IDLE is ignored; `wdata_valid` outside IDLE/FETCH is ignored.

## Timing
- All outputs registered.
- Reset values: all outputs 0; state IDLE; counters 0.
- Reset asserted mid-transfer: outputs go to 0 immediately (asynchronously). No `tx_done`.
- Latency:
  - Accept cycle → `m_valid`=1 next cycle.
  - First address bit on the cycle after `s_ready` is seen in WAIT_RDY.
- Read, no stalls: `m_valid` high for 1 + 12 cycles. `tx_done` follows the last bit by 1 cycle.
- Write of N beats with `wdata_valid` always high: `m_valid` high for 1 + 12 + 9·(N−1) cycles.
- The beat counter never wraps: `burst_len`=0 yields 1 beat, 4095 yields 4095 beats.
- `wdata_ready` is never high for two consecutive cycles.

## Structure
- Shared package `serial_bus_pkg` holds:
  - `ADDR_W`, `DATA_W`, `BURST_W` defaults;
  - the state enum `mop_state_t`;
  - the read/write encoding constants.
  The slave side reuses the same package.
- One sub-module, `serial_shift_out`: a parallel-load, LSB-first shift register with load, shift-enable (gated by `s_ready`) and serial out. It is instantiated twice: a 12-bit address instance and an 8-bit data instance.

## Test plan
- Read: addr 0xA5C, `s_ready`=1 → `read_enable`=1, `tx_address` sequence 0,0,1,1,1,0,1,0,0,1,0,1 (LSB first), `tx_data` all 0, `tx_done` 14 cycles after accept.
- Single write: addr 0x001, wdata 0xB3, `burst_len`=0 → 1 beat, `tx_data` 1,1,0,0,1,1,0,1 in ADDR cycles 0–7, `wdata_ready` pulses once.
- Burst write: `burst_len`=3, bytes 0x11, 0x22, 0x33 → three `wdata_ready` pulses, `m_valid` high 31 cycles, FETCH gaps of 1 cycle.
- Stall: drop `s_ready` for 3 cycles at ADDR bit 5 → bit 5 held 4 cycles, sequence resumes at bit 6, total length grows by 3.
- FETCH starvation: `wdata_valid`=0 for 5 cycles after first beat → `m_valid` stays 1, `tx_*`=0, DATA resumes on valid.
- Reset mid-DATA: assert `rst` at bit 3 → all outputs 0 at once, no `tx_done`, a new command after reset release completes normally.
